cavlc_enc_ctrl: RTL and testbench

Control and bit-packing block for the CAVLC encoder path, the transmit-side counterpart of the decoder control FSM.
- Sequences per-block code emission: coeff_token stage, then level stage (trailing-ones signs plus levels), then zero stage (total_zeros plus run_before).
- Muxes the active stage's variable-length code words into an MSB-first bit packer.
- Emits 32-bit words to the bitstream writer with ready/valid backpressure, and zero-pad flushes at end of stream.

---
 rtl/cavlc_enc_pkg.sv | 19 +
 rtl/cavlc_bit_packer.sv | 78 +++++++
 rtl/cavlc_enc_ctrl.sv | 170 +++++++++++++++++
 tb/tb_cavlc_enc_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cavlc_enc_pkg.sv
// Shared types and constants for the CAVLC encoder control path.
// Optional statistics port is enabled by CAVLC_ENC_STATS_EN.
package cavlc_enc_pkg;

    localparam int CODE_W = 32;
    localparam int WORD_W = 32;

    typedef logic [5:0] len_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BLOCK,
        COEFF_TOKEN,
        LEVEL_ENC,
        ZERO_ENC,
        FLUSH
    } state_t;

endpackage

// File: rtl/cavlc_bit_packer.sv
// MSB-first bit packer: 2*WORD_W accumulator, word pop with backpressure,
// zero-padded partial pop while flushing.
module cavlc_bit_packer #(
    parameter int CODE_W = 32,
    parameter int WORD_W = 32
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              push_valid,
    input  logic [CODE_W-1:0] push_code,
    input  logic [5:0]        push_len,
    input  logic              flush,
    input  logic              word_ready,
    output logic              room,
    output logic              empty,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data,
    output logic [5:0]        word_bits
);
    import cavlc_enc_pkg::*;

    localparam int ACC_W  = 2 * WORD_W;
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam logic [FILL_W-1:0] WORD_F = FILL_W'(WORD_W);
    localparam logic [FILL_W-1:0] ACC_F  = FILL_W'(ACC_W);

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_nxt;
    logic [ACC_W-1:0]  code_ext;
    logic [ACC_W-1:0]  placed;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt;
    logic [FILL_W-1:0] base;
    logic              pop;

    assign room       = fill <= WORD_F;
    assign empty      = fill == '0;
    assign word_valid = (fill >= WORD_F) || (flush && !empty);
    assign word_data  = acc[ACC_W-1 -: WORD_W];
    assign word_bits  = (empty || fill >= WORD_F) ? len_t'(WORD_W)
                                                  : len_t'(fill);
    assign pop        = word_valid && word_ready;

    always_comb begin
        acc_nxt  = acc;
        base     = fill;
        placed   = '0;
        code_ext = ACC_W'(push_code)
                 & ((ACC_W'(1) << push_len) - ACC_W'(1));
        if (pop) begin
            if (fill >= WORD_F) begin
                acc_nxt = acc << WORD_W;
                base    = fill - WORD_F;
            end else begin
                // flush partial: padding below fill is already zero
                acc_nxt = '0;
                base    = '0;
            end
        end
        fill_nxt = base;
        if (push_valid) begin
            placed   = code_ext << (ACC_F - base - FILL_W'(push_len));
            acc_nxt  = acc_nxt | placed;
            fill_nxt = base + FILL_W'(push_len);
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            acc  <= '0;
            fill <= '0;
        end else begin
            acc  <= acc_nxt;
            fill <= fill_nxt;
        end
    end

endmodule

// File: rtl/cavlc_enc_ctrl.sv
// CAVLC encoder control: stage sequencing and code word muxing into the packer.
// Define CAVLC_ENC_STATS_EN to add the BlockBits per-block bit counter.
module cavlc_enc_ctrl #(
    parameter int CODE_W = cavlc_enc_pkg::CODE_W,
    parameter int WORD_W = cavlc_enc_pkg::WORD_W
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              Enable,
    input  logic              BlockStart,
    input  logic [4:0]        TotalCoeff,
    input  logic [CODE_W-1:0] CoeffTokenCode,
    input  logic [5:0]        CoeffTokenLen,
    output logic              LevelEncodeEnable,
    output logic              ZeroEncodeEnable,
    input  logic              StageCodeValid,
    input  logic [CODE_W-1:0] StageCode,
    input  logic [5:0]        StageCodeLen,
    input  logic              StageLast,
    output logic              StageCodeReady,
    output logic              WordValid,
    output logic [WORD_W-1:0] WordData,
    output logic [5:0]        WordBits,
    input  logic              WordReady,
    output logic              BlockDone,
    output logic              FlushDone
`ifdef CAVLC_ENC_STATS_EN
    ,
    output logic [9:0]        BlockBits
`endif
);
    import cavlc_enc_pkg::*;

    localparam len_t MAX_LEN = len_t'(CODE_W);

    state_t            state;
    state_t            state_nxt;
    logic              tc_zero;
    logic              room;
    logic              empty;
    logic              push_valid;
    logic [CODE_W-1:0] push_code;
    len_t              push_len;

    // over-long codes are clamped so the accumulator can never overflow
    function automatic len_t clamp_len(input len_t l);
        return (l > MAX_LEN) ? MAX_LEN : l;
    endfunction

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state   <= IDLE;
            tc_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == WAIT_BLOCK && BlockStart)
                tc_zero <= TotalCoeff == 5'd0;
        end
    end

    always_comb begin
        state_nxt         = state;
        push_valid        = 1'b0;
        push_code         = StageCode;
        push_len          = clamp_len(StageCodeLen);
        StageCodeReady    = 1'b0;
        LevelEncodeEnable = 1'b0;
        ZeroEncodeEnable  = 1'b0;
        BlockDone         = 1'b0;
        FlushDone         = 1'b0;
        unique case (state)
            IDLE: begin
                if (Enable)
                    state_nxt = WAIT_BLOCK;
            end
            WAIT_BLOCK: begin
                if (BlockStart)
                    state_nxt = COEFF_TOKEN;
                else if (!Enable)
                    state_nxt = FLUSH;
            end
            COEFF_TOKEN: begin
                push_code = CoeffTokenCode;
                push_len  = clamp_len(CoeffTokenLen);
                if (room) begin
                    push_valid = 1'b1;
                    if (tc_zero) begin
                        BlockDone = 1'b1;
                        state_nxt = Enable ? WAIT_BLOCK : FLUSH;
                    end else begin
                        LevelEncodeEnable = 1'b1;
                        state_nxt         = LEVEL_ENC;
                    end
                end
            end
            LEVEL_ENC: begin
                StageCodeReady = room && StageCodeValid;
                push_valid     = StageCodeReady;
                if (StageCodeReady && StageLast) begin
                    ZeroEncodeEnable = 1'b1;
                    state_nxt        = ZERO_ENC;
                end
            end
            ZERO_ENC: begin
                StageCodeReady = room && StageCodeValid;
                push_valid     = StageCodeReady;
                if (StageCodeReady && StageLast) begin
                    BlockDone = 1'b1;
                    state_nxt = Enable ? WAIT_BLOCK : FLUSH;
                end
            end
            FLUSH: begin
                if (empty) begin
                    FlushDone = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    cavlc_bit_packer #(
        .CODE_W (CODE_W),
        .WORD_W (WORD_W)
    ) u_packer (
        .Clk        (Clk),
        .nReset     (nReset),
        .push_valid (push_valid),
        .push_code  (push_code),
        .push_len   (push_len),
        .flush      (state == FLUSH),
        .word_ready (WordReady),
        .room       (room),
        .empty      (empty),
        .word_valid (WordValid),
        .word_data  (WordData),
        .word_bits  (WordBits)
    );

`ifdef CAVLC_ENC_STATS_EN
    logic [9:0] bit_cnt;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            bit_cnt   <= '0;
            BlockBits <= '0;
        end else if (push_valid) begin
            if (BlockDone) begin
                BlockBits <= bit_cnt + 10'(push_len);
                bit_cnt   <= '0;
            end else begin
                bit_cnt <= bit_cnt + 10'(push_len);
            end
        end
    end
`else
    // no per-block statistics in this build
`endif

    a_stage_len: assert property (@(posedge Clk) disable iff (!nReset)
        (StageCodeValid && (state == LEVEL_ENC || state == ZERO_ENC))
        |-> StageCodeLen <= MAX_LEN);

    a_token_len: assert property (@(posedge Clk) disable iff (!nReset)
        (state == COEFF_TOKEN) |-> CoeffTokenLen <= MAX_LEN);

    a_block_start: assert property (@(posedge Clk) disable iff (!nReset)
        BlockStart |-> state == WAIT_BLOCK);

endmodule

// File: tb/tb_cavlc_enc_ctrl.sv
// Directed and randomised bench for cavlc_enc_ctrl against a bit-queue model.
// Covers BlockBits when built with CAVLC_ENC_STATS_EN.
module tb_cavlc_enc_ctrl;

    logic        Clk = 1'b0;
    logic        nReset = 1'b0;
    logic        Enable = 1'b0;
    logic        BlockStart = 1'b0;
    logic [4:0]  TotalCoeff = '0;
    logic [31:0] CoeffTokenCode = '0;
    logic [5:0]  CoeffTokenLen = '0;
    logic        LevelEncodeEnable;
    logic        ZeroEncodeEnable;
    logic        StageCodeValid = 1'b0;
    logic [31:0] StageCode = '0;
    logic [5:0]  StageCodeLen = '0;
    logic        StageLast = 1'b0;
    logic        StageCodeReady;
    logic        WordValid;
    logic [31:0] WordData;
    logic [5:0]  WordBits;
    logic        WordReady = 1'b1;
    logic        BlockDone;
    logic        FlushDone;
`ifdef CAVLC_ENC_STATS_EN
    logic [9:0]  BlockBits;
`endif

    int n_cmp = 0;
    int n_fail = 0;
    int bd_n = 0;
    int lvl_n = 0;
    int zro_n = 0;
    int fd_n = 0;
    int blk_bits = 0;
    bit rnd_ready = 1'b0;

    bit          exp_q[$];
    logic [31:0] rx_data[$];
    logic [5:0]  rx_bits[$];

    cavlc_enc_ctrl dut (
        .Clk               (Clk),
        .nReset            (nReset),
        .Enable            (Enable),
        .BlockStart        (BlockStart),
        .TotalCoeff        (TotalCoeff),
        .CoeffTokenCode    (CoeffTokenCode),
        .CoeffTokenLen     (CoeffTokenLen),
        .LevelEncodeEnable (LevelEncodeEnable),
        .ZeroEncodeEnable  (ZeroEncodeEnable),
        .StageCodeValid    (StageCodeValid),
        .StageCode         (StageCode),
        .StageCodeLen      (StageCodeLen),
        .StageLast         (StageLast),
        .StageCodeReady    (StageCodeReady),
        .WordValid         (WordValid),
        .WordData          (WordData),
        .WordBits          (WordBits),
        .WordReady         (WordReady),
        .BlockDone         (BlockDone),
        .FlushDone         (FlushDone)
`ifdef CAVLC_ENC_STATS_EN
        ,
        .BlockBits         (BlockBits)
`endif
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (nReset) begin
            if (BlockDone)         bd_n  <= bd_n + 1;
            if (LevelEncodeEnable) lvl_n <= lvl_n + 1;
            if (ZeroEncodeEnable)  zro_n <= zro_n + 1;
            if (FlushDone)         fd_n  <= fd_n + 1;
            if (WordValid && WordReady) begin
                rx_data.push_back(WordData);
                rx_bits.push_back(WordBits);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        if (rnd_ready)
            WordReady = ($urandom_range(0, 9) < 7);
    endtask

    task automatic model_push(input logic [31:0] code, input int len);
        for (int i = len - 1; i >= 0; i--)
            exp_q.push_back(code[i]);
        blk_bits += len;
    endtask

    task automatic block_stats();
`ifdef CAVLC_ENC_STATS_EN
        chk("block_bits", 64'(BlockBits), 64'(blk_bits[9:0]));
`endif
    endtask

    task automatic stage_push(input logic [31:0] code, input int len,
                              input bit last);
        bit ok;
        ok = 1'b0;
        StageCode      = code;
        StageCodeLen   = 6'(len);
        StageLast      = last;
        StageCodeValid = 1'b1;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge Clk);
            if (StageCodeReady) begin
                ok = 1'b1;
                model_push(code, len);
            end
            tick();
        end
        StageCodeValid = 1'b0;
        StageLast      = 1'b0;
        chk("stage_accept", 64'(ok), 64'd1);
    endtask

    task automatic wait_block_done();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge Clk);
            if (BlockDone) ok = 1'b1;
            tick();
        end
        chk("block_done_seen", 64'(ok), 64'd1);
        block_stats();
    endtask

    task automatic start_block(input int tc, input logic [31:0] code,
                               input int len);
        TotalCoeff     = 5'(tc);
        CoeffTokenCode = code;
        CoeffTokenLen  = 6'(len);
        BlockStart     = 1'b1;
        tick();
        BlockStart = 1'b0;
        blk_bits   = 0;
        model_push(code, len);
        if (tc == 0)
            wait_block_done();
    endtask

    task automatic end_stream();
        bit ok;
        ok = 1'b0;
        Enable = 1'b0;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge Clk);
            if (FlushDone) ok = 1'b1;
            tick();
        end
        chk("flush_done_seen", 64'(ok), 64'd1);
        Enable = 1'b1;
        tick();
    endtask

    task automatic clear_all();
        exp_q.delete();
        rx_data.delete();
        rx_bits.delete();
    endtask

    task automatic compare_stream(input string tag);
        bit rx[$];
        int bad;
        int n;
        bad = 0;
        foreach (rx_data[k]) begin
            for (int i = 0; i < 32; i++) begin
                if (i < int'(rx_bits[k])) rx.push_back(rx_data[k][31-i]);
                else if (rx_data[k][31-i]) bad++;
            end
            if (k != rx_data.size() - 1 && rx_bits[k] != 6'd32) bad++;
        end
        chk({tag, "_len"}, 64'(rx.size()), 64'(exp_q.size()));
        n = (rx.size() < exp_q.size()) ? rx.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (rx[i] != exp_q[i]) bad++;
        chk({tag, "_bits"}, 64'(bad), 64'd0);
        clear_all();
    endtask

    int b0, l0, z0, f0, rdy, tc, nw;

    initial begin
        // reset state
        repeat (2) @(negedge Clk);
        chk("rst_ctl", 64'({WordValid, StageCodeReady, LevelEncodeEnable,
                            ZeroEncodeEnable, BlockDone, FlushDone}), 64'd0);
        chk("rst_bits", 64'(WordBits), 64'd32);
        chk("rst_data", 64'(WordData), 64'd0);
        nReset = 1'b1;
        Enable = 1'b1;
        tick();

        // T1: empty block, Enable dropped during the block
        b0 = bd_n; l0 = lvl_n; z0 = zro_n; f0 = fd_n;
        TotalCoeff     = 5'd0;
        CoeffTokenCode = 32'h1;
        CoeffTokenLen  = 6'd1;
        BlockStart     = 1'b1;
        tick();
        BlockStart = 1'b0;
        Enable     = 1'b0;
        blk_bits   = 0;
        model_push(32'h1, 1);
        end_stream();
        chk("t1_nwords", 64'(rx_data.size()), 64'd1);
        chk("t1_data", 64'(rx_data[0]), 64'h8000_0000);
        chk("t1_bits", 64'(rx_bits[0]), 64'd1);
        chk("t1_bdone", 64'(bd_n - b0), 64'd1);
        chk("t1_lvl_en", 64'(lvl_n - l0), 64'd0);
        chk("t1_zero_en", 64'(zro_n - z0), 64'd0);
        chk("t1_fdone", 64'(fd_n - f0), 64'd1);
        block_stats();
        clear_all();

        // T2: 12 codes of 101 -> 36 bits
        l0 = lvl_n; z0 = zro_n;
        start_block(3, 32'h5, 3);
        for (int i = 0; i < 10; i++)
            stage_push(32'h5, 3, i == 9);
        stage_push(32'h5, 3, 1'b1);
        block_stats();
        end_stream();
        chk("t2_w0", 64'(rx_data[0]), 64'hB6DB_6DB6);
        chk("t2_b0", 64'(rx_bits[0]), 64'd32);
        chk("t2_w1", 64'(rx_data[1]), 64'hD000_0000);
        chk("t2_b1", 64'(rx_bits[1]), 64'd4);
        chk("t2_lvl_en", 64'(lvl_n - l0), 64'd1);
        chk("t2_zero_en", 64'(zro_n - z0), 64'd1);
        compare_stream("t2");

        // T3: backpressure with fill=40
        WordReady = 1'b0;
        start_block(1, 32'hA5, 8);
        stage_push(32'h1234_5678, 32, 1'b0);
        StageCode      = 32'h0F0F_0F0F;
        StageCodeLen   = 6'd32;
        StageLast      = 1'b1;
        StageCodeValid = 1'b1;
        rdy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (StageCodeReady) rdy++;
            tick();
        end
        chk("t3_stall_ready", 64'(rdy), 64'd0);
        @(negedge Clk);
        chk("t3_stall_valid", 64'(WordValid), 64'd1);
        chk("t3_stall_data", 64'(WordData), 64'hA512_3456);
        tick();
        WordReady = 1'b1;
        stage_push(32'h0F0F_0F0F, 32, 1'b1);
        stage_push(32'h3, 2, 1'b1);
        block_stats();
        end_stream();
        chk("t3_nwords", 64'(rx_data.size()), 64'd3);
        compare_stream("t3");

        // T4: zero-length stage words still advance the stages
        l0 = lvl_n; z0 = zro_n; b0 = bd_n;
        start_block(2, 32'h3, 2);
        stage_push(32'hFFFF_FFFF, 0, 1'b1);
        stage_push(32'hFFFF_FFFF, 0, 1'b1);
        block_stats();
        chk("t4_lvl_en", 64'(lvl_n - l0), 64'd1);
        chk("t4_zero_en", 64'(zro_n - z0), 64'd1);
        chk("t4_bdone", 64'(bd_n - b0), 64'd1);
        @(negedge Clk);
        chk("t4_no_word", 64'(WordValid), 64'd0);
        end_stream();
        chk("t4_data", 64'(rx_data[0]), 64'hC000_0000);
        chk("t4_bits", 64'(rx_bits[0]), 64'd2);
        compare_stream("t4");

        // T5: reset in LEVEL_ENC with fill=20
        start_block(1, 32'hABCDE, 20);
        tick();
        StageCode      = 32'h1F;
        StageCodeLen   = 6'd5;
        StageCodeValid = 1'b1;
        @(negedge Clk);
        chk("t5_pre_ready", 64'(StageCodeReady), 64'd1);
        nReset = 1'b0;
        #1;
        chk("t5_rst_ctl", 64'({WordValid, StageCodeReady, LevelEncodeEnable,
                               ZeroEncodeEnable, BlockDone, FlushDone}), 64'd0);
        chk("t5_rst_bits", 64'(WordBits), 64'd32);
        chk("t5_rst_data", 64'(WordData), 64'd0);
        StageCodeValid = 1'b0;
        clear_all();
        @(negedge Clk);
        nReset = 1'b1;
        tick();
        start_block(0, 32'h3, 2);
        end_stream();
        chk("t5_nwords", 64'(rx_data.size()), 64'd1);
        chk("t5_data", 64'(rx_data[0]), 64'hC000_0000);
        chk("t5_bits", 64'(rx_bits[0]), 64'd2);
        clear_all();

        // T6: random blocks, random WordReady
        rnd_ready = 1'b1;
        for (int b = 0; b < 300; b++) begin
            tc = int'($urandom_range(0, 16));
            start_block(tc, $urandom, int'($urandom_range(1, 16)));
            if (tc != 0) begin
                nw = int'($urandom_range(1, 4));
                for (int i = 0; i < nw; i++)
                    stage_push($urandom, int'($urandom_range(0, 32)),
                               i == nw - 1);
                nw = int'($urandom_range(1, 3));
                for (int i = 0; i < nw; i++)
                    stage_push($urandom, int'($urandom_range(0, 32)),
                               i == nw - 1);
                block_stats();
            end
        end
        end_stream();
        rnd_ready = 1'b0;
        WordReady = 1'b1;
        compare_stream("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
